pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit_pkg.sv | 15 +
 rtl/pc_stack_unit_ret_stack.sv | 49 ++++
 rtl/pc_stack_unit.sv | 97 +++++++++
 tb/tb_pc_stack_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_unit_pkg.sv
// Shared constants for the program-counter / return-stack unit.
// Holds default widths, the occupancy-counter width rule and the reset vector.
package pc_stack_unit_pkg;

  localparam int          PC_W   = 8;
  localparam int          DEPTH  = 4;
  localparam int          CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PC_RST = 0;

  // The counter must represent 0..depth inclusive, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO with an occupancy counter.
// The caller guarantees push and pop are never both requested in one cycle.
module ret_stack #(
  parameter int W     = pc_stack_unit_pkg::PC_W,
  parameter int DEPTH = pc_stack_unit_pkg::DEPTH,
  parameter int CW    = pc_stack_unit_pkg::count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  // With DEPTH a power of two, the low bits of count address the next free slot.
  assign wr_idx  = count[AW-1:0];
  assign top_idx = AW'(count - CW'(1));
  assign rdata   = mem[top_idx];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; clearing count alone hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack: return > jump > increment,
// call = jump + push of pc+1, sticky overflow/underflow flag.
module pc_stack_unit #(
  parameter int PC_W  = pc_stack_unit_pkg::PC_W,
  parameter int DEPTH = pc_stack_unit_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            jump1,
  input  logic            jump2,
  input  logic            ret1,
  input  logic            push1,
  input  logic            push2,
  input  logic [PC_W-1:0] addr,
  output logic [PC_W-1:0] pc,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_err
);

  import pc_stack_unit_pkg::*;

  localparam int CW = count_width(DEPTH);

  logic            jmp;
  logic            psh;
  logic            do_push;
  logic            do_pop;
  logic            st_full;
  logic            st_empty;
  logic [CW-1:0]   count;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] top_data;
  logic [PC_W-1:0] pc_next;
  logic            err_next;

  assign jmp    = jump1 | jump2;
  assign psh    = push1 | push2;
  assign pc_inc = pc + PC_W'(1);

  // A return masks any simultaneous push; failed pushes/pops never reach the LIFO.
  assign do_pop  = en & ret1 & ~st_empty;
  assign do_push = en & ~ret1 & psh & ~st_full;

  ret_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (pc_inc),
    .rdata (top_data),
    .full  (st_full),
    .empty (st_empty),
    .count (count)
  );

  assign stack_empty = (count == '0);
  assign stack_full  = (count == CW'(DEPTH));

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    pc_next  = pc;
    err_next = stack_err;
    if (en) begin
      if (ret1) begin
        if (!st_empty) begin
          pc_next = top_data;
        end else begin
          pc_next  = pc_inc;
          err_next = 1'b1;
        end
      end else begin
        pc_next = jmp ? addr : pc_inc;
        if (psh && st_full) begin
          err_next = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= PC_W'(PC_RST);
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      stack_err <= err_next;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed scenarios plus random traffic
// against a queue-based reference model of the return stack.
module tb_pc_stack_unit;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            empty;
    logic            full;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0;
  logic            jump1 = 1'b0;
  logic            jump2 = 1'b0;
  logic            ret1 = 1'b0;
  logic            push1 = 1'b0;
  logic            push2 = 1'b0;
  logic [PC_W-1:0] addr = '0;
  logic [PC_W-1:0] pc;
  logic            stack_empty;
  logic            stack_full;
  logic            stack_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: plain LIFO queue of return addresses.
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_stk[$];
  logic            m_err;
  exp_t            exp_q[$];

  pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .jump1       (jump1),
    .jump2       (jump2),
    .ret1        (ret1),
    .push1       (push1),
    .push2       (push2),
    .addr        (addr),
    .pc          (pc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PC_W-1:0] got, input logic [PC_W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  function automatic void model_reset();
    m_pc  = '0;
    m_err = 1'b0;
    m_stk.delete();
  endfunction

  function automatic exp_t model_step(input logic e, input logic j, input logic r,
                                      input logic p, input logic [PC_W-1:0] a);
    exp_t            x;
    logic [PC_W-1:0] seq;
    seq = PC_W'(m_pc + PC_W'(1));
    if (e) begin
      if (r) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = seq;
          m_err = 1'b1;
        end
      end else begin
        if (p) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(seq);
          else m_err = 1'b1;
        end
        m_pc = j ? a : seq;
      end
    end
    x.pc    = m_pc;
    x.empty = (m_stk.size() == 0);
    x.full  = (m_stk.size() == DEPTH);
    x.err   = m_err;
    return x;
  endfunction

  task automatic drive(input logic e, input logic j1, input logic j2, input logic r,
                       input logic p1, input logic p2, input logic [PC_W-1:0] a);
    en = e; jump1 = j1; jump2 = j2; ret1 = r; push1 = p1; push2 = p2; addr = a;
  endtask

  task automatic cycle(input logic e, input logic j1, input logic j2, input logic r,
                       input logic p1, input logic p2, input logic [PC_W-1:0] a);
    @(negedge clk);
    drive(e, j1, j2, r, p1, p2, a);
    exp_q.push_back(model_step(e, j1 | j2, r, p1 | p2, a));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 8'h00);
    check({tag, "_empty"}, {7'd0, stack_empty}, 8'h01);
    check({tag, "_full"}, {7'd0, stack_full}, 8'h00);
    check({tag, "_err"}, {7'd0, stack_err}, 8'h00);
  endtask

  // Reset asserted and released between clock edges; the following edge is a stall.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1 check_reset_state("reset");
    model_reset();
    #1 rst_n = 1'b1;
    exp_q.push_back(model_step(1'b0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  // Reset pulse while a return is being presented; the return must not survive it.
  task automatic mid_ret_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    #1 rst_n = 1'b0;
    #1 check_reset_state("midret");
    model_reset();
    #1 rst_n = 1'b1;
    exp_q.push_back(model_step(1'b1, 1'b0, 1'b1, 1'b0, '0));
  endtask

  // Monitor: one registered result per rising edge that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("stack_empty", {7'd0, stack_empty}, {7'd0, e.empty});
        check("stack_full", {7'd0, stack_full}, {7'd0, e.full});
        check("stack_err", {7'd0, stack_err}, {7'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    model_reset();

    // Plain sequencing from reset.
    do_reset();
    repeat (3) cycle(1, 0, 0, 0, 0, 0, '0);

    // Single call and return.
    cycle(1, 1, 0, 0, 0, 0, 8'h10);
    cycle(1, 1, 0, 0, 1, 0, 8'h40);
    cycle(1, 0, 0, 1, 0, 0, '0);

    // Four nested calls, overflowing fifth call, four returns.
    cycle(1, 0, 1, 0, 0, 0, 8'h01);
    cycle(1, 1, 0, 0, 1, 0, 8'h21);
    cycle(1, 0, 1, 0, 0, 1, 8'h41);
    cycle(1, 1, 0, 0, 0, 1, 8'h61);
    cycle(1, 0, 1, 0, 1, 0, 8'h81);
    cycle(1, 1, 0, 0, 1, 0, 8'h90);
    repeat (4) cycle(1, 0, 0, 1, 0, 0, '0);

    // Underflow from an empty stack; error is sticky.
    do_reset();
    cycle(1, 1, 0, 0, 0, 0, 8'h05);
    cycle(1, 0, 0, 1, 0, 0, '0);
    repeat (10) cycle(1, 0, 0, 0, 0, 0, '0);

    // Wrap at all-ones, then a stalled jump.
    cycle(1, 1, 0, 0, 0, 0, 8'hFF);
    cycle(1, 0, 0, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 0, 0, 8'h33);
    cycle(0, 1, 0, 1, 1, 1, 8'h77);

    // Return with a simultaneous push, then reset in the middle of a return.
    cycle(1, 1, 0, 0, 1, 0, 8'h30);
    cycle(1, 0, 0, 1, 1, 1, '0);
    cycle(1, 1, 0, 0, 1, 0, 8'h50);
    cycle(1, 0, 1, 0, 0, 1, 8'h70);
    mid_ret_reset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      cycle($urandom_range(0, 9) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            PC_W'($urandom));
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
